// File: rtl/mem_pkg.sv
// Shared definitions for the mem_ram block: FSM state encoding.
package mem_pkg;

    // Controller states: CLEAR zeroes the array word by word, IDLE serves requests.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage : mem_pkg

// File: rtl/mem_ram_array.sv
// Storage array for mem_ram: one byte-enabled write port and one
// synchronous read port. Holds no control state and has no reset.
module mem_ram_array #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NBYTES     = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [NBYTES-1:0]     i_wbe,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-masked write and registered read; read register holds when idle.
    // NOTE: the array has no reset so it maps onto block RAM; zeroing is done
    // by the controller's CLEAR sequence writing every word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (i_wbe[k]) begin
                    r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : mem_ram_array

// File: rtl/mem_ram.sv
// Single-port RAM with byte enables, valid/ready request handshake,
// one-cycle read latency and an optional clear-after-reset sequence.
module mem_ram
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    output logic                    o_rvalid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_busy
);

    localparam int                    NBYTES   = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = {ADDR_WIDTH{1'b1}};
    localparam state_t                ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t                r_state;
    logic                  r_ready;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_rvalid;
    logic                  r_have_data;

    logic                  w_accept;
    logic                  w_rd;
    logic                  w_arr_we;
    logic [ADDR_WIDTH-1:0] w_arr_waddr;
    logic [DATA_WIDTH-1:0] w_arr_wdata;
    logic [NBYTES-1:0]     w_arr_wbe;
    logic [DATA_WIDTH-1:0] w_arr_rdata;

    assign w_accept = i_req_valid && r_ready;
    assign w_rd     = w_accept && !i_we;

    // Write-port steering: clear sequence owns the port in CLEAR, requests in IDLE.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        w_arr_we    = 1'b0;
        w_arr_waddr = i_addr;
        w_arr_wdata = i_wdata;
        w_arr_wbe   = i_be;
        if (r_state == ST_CLEAR) begin
            w_arr_we    = 1'b1;
            w_arr_waddr = r_clr_cnt;
            w_arr_wdata = '0;
            w_arr_wbe   = '1;
        end else if (w_accept && i_we) begin
            w_arr_we    = 1'b1;
        end
    end

    // Controller FSM with registered ready/busy, clear counter and read strobe.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_RESET;
            r_busy      <= CLEAR_ON_RESET;
            r_ready     <= !CLEAR_ON_RESET;
            r_clr_cnt   <= '0;
            r_rvalid    <= 1'b0;
            r_have_data <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_have_data <= 1'b1;
            end
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NBYTES     (NBYTES)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_arr_we),
        .i_waddr (w_arr_waddr),
        .i_wdata (w_arr_wdata),
        .i_wbe   (w_arr_wbe),
        .i_re    (w_rd),
        .i_raddr (i_addr),
        .o_rdata (w_arr_rdata)
    );

    // The array read register has no reset, so read data is masked to zero
    // until the first read after reset has loaded it.
    assign o_rdata     = r_have_data ? w_arr_rdata : '0;
    assign o_rvalid    = r_rvalid;
    assign o_req_ready = r_ready;
    assign o_busy      = r_busy;

endmodule : mem_ram

// File: tb/tb_mem_ram.sv
// Directed self-checking bench for mem_ram: one instance with clear on reset,
// one without, both with a 16-word x 32-bit array.
module tb_mem_ram;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          busy;

    logic          rst_b;
    logic          req_valid_b;
    logic          req_ready_b;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata_b;
    logic [3:0]    be_b;
    logic          rvalid_b;
    logic [DW-1:0] rdata_b;
    logic          busy_b;

    int n_checks = 0;
    int n_err    = 0;
    int n_cyc;

    always #5 clk = ~clk;

    mem_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .i_be        (be),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_busy      (busy)
    );

    mem_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b0)) dut_b (
        .i_clk       (clk),
        .i_rst       (rst_b),
        .i_req_valid (req_valid_b),
        .o_req_ready (req_ready_b),
        .i_we        (we_b),
        .i_addr      (addr_b),
        .i_wdata     (wdata_b),
        .i_be        (be_b),
        .o_rvalid    (rvalid_b),
        .o_rdata     (rdata_b),
        .o_busy      (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; leaves the bench just after the next one.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
        req_valid = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        req_valid = 1'b0; we = 1'b0;
        check("no_rvalid_after_write", rvalid, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        req_valid = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("read_rvalid", rvalid, 1);
        check($sformatf("read_data_a%0d", a), rdata, exp);
    endtask

    task automatic count_busy(input string tag);
        n_cyc = 0;
        while (busy && n_cyc < 100) begin
            @(posedge clk); #1;
            n_cyc++;
        end
        check(tag, n_cyc, 16);
        check("ready_after_clear", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        rst_b = 1'b1; req_valid_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = '0;
        #1;
        check("rst_busy", busy, 1);
        check("rst_ready", req_ready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("b_rst_busy", busy_b, 0);
        check("b_rst_ready", req_ready_b, 1);

        // Clear after reset takes exactly 16 cycles, then every word reads 0.
        @(negedge clk); rst = 1'b0;
        count_busy("clear_cycles");
        for (int i = 0; i < 16; i++) do_read(AW'(i), 32'h0);

        // Byte-masked write then read-after-write of the same address.
        do_write(4'd3, 32'hDEADBEEF, 4'b1111);
        do_write(4'd3, 32'h00000011, 4'b0001);
        do_read(4'd3, 32'hDEADBE11);
        @(posedge clk); #1;
        check("rvalid_single_pulse", rvalid, 0);
        check("rdata_hold", rdata, 32'hDEADBE11);

        // Back-to-back reads give consecutive pulses in order.
        for (int i = 0; i < 4; i++) do_write(AW'(i), 32'hA0 + i, 4'b1111);
        req_valid = 1'b1; we = 1'b0; addr = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) addr = AW'(i + 1);
            else req_valid = 1'b0;
            check("b2b_rvalid", rvalid, 1);
            check("b2b_rdata", rdata, 32'hA0 + i);
        end
        @(posedge clk); #1;
        check("b2b_rvalid_end", rvalid, 0);

        // Write with no byte enables is a no-op.
        do_write(4'd5, 32'h12345678, 4'b1111);
        do_write(4'd5, 32'hFFFFFFFF, 4'b0000);
        do_read(4'd5, 32'h12345678);

        // Top and bottom addresses behave normally.
        do_write(4'd15, 32'hCAFEF00D, 4'b1111);
        do_read(4'd15, 32'hCAFEF00D);
        do_read(4'd0, 32'hA0);

        // Reset in the response cycle kills the pulse and the read data.
        req_valid = 1'b1; we = 1'b0; addr = 4'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1; #1;
        check("rst_kills_rvalid", rvalid, 0);
        check("rst_kills_rdata", rdata, 0);
        check("rst_busy_again", busy, 1);
        @(negedge clk); rst = 1'b0;

        // Reset at clear cycle 7 restarts a full 16-cycle clear.
        repeat (7) begin @(posedge clk); #1; end
        check("busy_mid_clear", busy, 1);
        rst = 1'b1; #1;
        check("busy_in_reset", busy, 1);
        @(negedge clk); rst = 1'b0;
        count_busy("restart_clear_cycles");
        for (int i = 0; i < 16; i++) do_read(AW'(i), 32'h0);

        // Without clear on reset, contents survive and requests are served at once.
        @(negedge clk); rst_b = 1'b0;
        @(posedge clk); #1;
        req_valid_b = 1'b1; we_b = 1'b1; addr_b = 4'd2; wdata_b = 32'h55; be_b = 4'b1111;
        @(posedge clk); #1;
        req_valid_b = 1'b0; we_b = 1'b0;
        rst_b = 1'b1; #1;
        check("b_rst_ready_pulse", req_ready_b, 1);
        check("b_rst_rdata", rdata_b, 0);
        @(negedge clk); rst_b = 1'b0;
        #1;
        check("b_ready_after_rst", req_ready_b, 1);
        check("b_busy_after_rst", busy_b, 0);
        @(posedge clk); #1;
        req_valid_b = 1'b1; addr_b = 4'd2;
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        check("b_rvalid", rvalid_b, 1);
        check("b_survive_data", rdata_b, 32'h55);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_mem_ram
